mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arb_rr.sv | 16 +
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 256;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_ISSUE = 2'd1;
    localparam arb_state_t ST_DONE  = 2'd2;

    typedef logic req_id_t;
    localparam req_id_t REQ_ICACHE = 1'b0;
    localparam req_id_t REQ_DCACHE = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester and Data_Memory signals around mem_arbiter.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              req0_enable, req1_enable;
    logic              req0_write,  req1_write;
    logic [ADDR_W-1:0] req0_addr,   req1_addr;
    logic [DATA_W-1:0] req0_wdata,  req1_wdata;
    logic              req0_ack,    req1_ack;
    logic [DATA_W-1:0] req0_rdata,  req1_rdata;
    logic              mem_enable;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport arb (
        input  req0_enable, req1_enable, req0_write, req1_write,
               req0_addr, req1_addr, req0_wdata, req1_wdata,
               mem_ack, mem_rdata,
        output req0_ack, req1_ack, req0_rdata, req1_rdata,
               mem_enable, mem_write, mem_addr, mem_wdata
    );

    modport env (
        output req0_enable, req1_enable, req0_write, req1_write,
               req0_addr, req1_addr, req0_wdata, req1_wdata,
               mem_ack, mem_rdata,
        input  req0_ack, req1_ack, req0_rdata, req1_rdata,
               mem_enable, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_rr.sv
// 2-way round-robin picker: on a tie the requester not granted last wins.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_id_t    last_i,
    output req_id_t    gnt_o
);

    always_comb begin
        gnt_o = REQ_ICACHE;
        if (req_i == 2'b11) gnt_o = ~last_i;
        else if (req_i[1])  gnt_o = REQ_DCACHE;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache/D-cache line transfers onto one Data_Memory port.
// MEM_ARB_FIXED_PRIO_EN: D-cache always wins ties, no last-grant register.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_enable_i,
    input  logic              req1_enable_i,
    input  logic              req0_write_i,
    input  logic              req1_write_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req0_data_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic              req0_ack_o,
    output logic              req1_ack_o,
    output logic [DATA_W-1:0] req0_data_o,
    output logic [DATA_W-1:0] req1_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i
);

    arb_state_t        state_q, state_d;
    req_id_t           grant_q, grant_d;
    logic              grant_vld_q, grant_vld_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [1:0]        req;
    req_id_t           pick;
    req_id_t           last_grant;

    assign req = {req1_enable_i, req0_enable_i};

    mem_arb_rr u_rr (
        .req_i  (req),
        .last_i (last_grant),
        .gnt_o  (pick)
    );

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Pretending the I-cache was granted last makes the D-cache win every tie.
    assign last_grant = REQ_ICACHE;
`else
    req_id_t last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (state_q == ST_IDLE && |req) last_d = pick;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) last_q <= REQ_DCACHE;
        else        last_q <= last_d;
    end

    assign last_grant = last_q;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_vld_d = grant_vld_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d     = pick;
                    grant_vld_d = 1'b1;
                    mem_write_d = (pick == REQ_DCACHE) ? req1_write_i : req0_write_i;
                    mem_addr_d  = (pick == REQ_DCACHE) ? req1_addr_i  : req0_addr_i;
                    mem_data_d  = (pick == REQ_DCACHE) ? req1_data_i  : req0_data_i;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: if (mem_ack_i) state_d = ST_DONE;
            // One enable-low cycle lets the memory restart its latency counter.
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            grant_q     <= REQ_ICACHE;
            grant_vld_q <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_vld_q <= grant_vld_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
        end
    end

    assign mem_enable_o = (state_q == ST_ISSUE);
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

    // A requester that dropped enable mid-transfer gets no ack.
    assign req0_ack_o = mem_ack_i && mem_enable_o && (grant_q == REQ_ICACHE) && req0_enable_i;
    assign req1_ack_o = mem_ack_i && mem_enable_o && (grant_q == REQ_DCACHE) && req1_enable_i;

    assign req0_data_o = (grant_vld_q && grant_q == REQ_ICACHE) ? mem_data_i : '0;
    assign req1_data_o = (grant_vld_q && grant_q == REQ_DCACHE) ? mem_data_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 10-cycle-latency line memory model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 256;
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam int FIXED = 1;
`else
    localparam int FIXED = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] mem [64];
    int            mcnt;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .req0_enable_i (bus.req0_enable),
        .req1_enable_i (bus.req1_enable),
        .req0_write_i  (bus.req0_write),
        .req1_write_i  (bus.req1_write),
        .req0_addr_i   (bus.req0_addr),
        .req1_addr_i   (bus.req1_addr),
        .req0_data_i   (bus.req0_wdata),
        .req1_data_i   (bus.req1_wdata),
        .req0_ack_o    (bus.req0_ack),
        .req1_ack_o    (bus.req1_ack),
        .req0_data_o   (bus.req0_rdata),
        .req1_data_o   (bus.req1_rdata),
        .mem_enable_o  (bus.mem_enable),
        .mem_write_o   (bus.mem_write),
        .mem_addr_o    (bus.mem_addr),
        .mem_data_o    (bus.mem_wdata),
        .mem_ack_i     (bus.mem_ack),
        .mem_data_i    (bus.mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] line_init(input int i);
        if (i == 16) return {2{128'h0123456789abcdeffedcba9876543210}};
        return {8{32'hA500_0000 | 32'(i)}};
    endfunction

    // Memory model: ack 10 cycles after enable rises, 32-byte lines.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt          <= 0;
            bus.mem_ack   <= 1'b0;
            bus.mem_rdata <= '0;
            for (int i = 0; i < 64; i++) mem[i] <= line_init(i);
        end else begin
            bus.mem_ack   <= 1'b0;
            bus.mem_rdata <= '0;
            if (bus.mem_enable && !bus.mem_ack) begin
                if (mcnt == 9) begin
                    mcnt        <= 0;
                    bus.mem_ack <= 1'b1;
                    if (bus.mem_write) mem[bus.mem_addr[10:5]] <= bus.mem_wdata;
                    else               bus.mem_rdata <= mem[bus.mem_addr[10:5]];
                end else begin
                    mcnt <= mcnt + 1;
                end
            end else begin
                mcnt <= 0;
            end
        end
    end

    task automatic drive0(input logic en, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req0_enable = en; bus.req0_write = wr; bus.req0_addr = a; bus.req0_wdata = d;
    endtask

    task automatic drive1(input logic en, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req1_enable = en; bus.req1_write = wr; bus.req1_addr = a; bus.req1_wdata = d;
    endtask

    // Waits (bounded) for either ack; who = -1 on timeout.
    task automatic wait_any_ack(output int who, output int cyc, output logic [DW-1:0] d);
        who = -1; cyc = 0; d = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.req0_ack) begin who = 0; cyc = i; d = bus.req0_rdata; break; end
            if (bus.req1_ack) begin who = 1; cyc = i; d = bus.req1_rdata; break; end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive0(1'b1, 1'b1, 32'h0000_0200, {8{32'hDEAD_BEEF}});
        drive1(1'b1, 1'b1, 32'h0000_0400, {8{32'hCAFE_F00D}});
        repeat (2) @(negedge clk);
        checks++; if (bus.mem_enable !== 1'b0) begin errors++; $display("FAIL rst_mem_enable got=%b exp=0", bus.mem_enable); end
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write got=%b exp=0", bus.mem_write); end
        checks++; if (bus.mem_addr !== '0) begin errors++; $display("FAIL rst_mem_addr got=%h exp=0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== '0) begin errors++; $display("FAIL rst_mem_data got=%h exp=0", bus.mem_wdata); end
        checks++; if ({bus.req1_ack, bus.req0_ack} !== 2'b00) begin errors++; $display("FAIL rst_acks got=%b exp=00", {bus.req1_ack, bus.req0_ack}); end
        checks++; if ((bus.req0_rdata | bus.req1_rdata) !== '0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", bus.req0_rdata | bus.req1_rdata); end
        do_reset();
    endtask

    task automatic test_single_fill();
        int who, cyc; logic [DW-1:0] d;
        @(posedge clk); #1 drive0(1'b1, 1'b0, 32'h0000_0200, '0);
        @(negedge clk);
        checks++; if (bus.mem_enable !== 1'b0) begin errors++; $display("FAIL single_en_early got=%b exp=0", bus.mem_enable); end
        @(negedge clk);
        checks++; if (bus.mem_enable !== 1'b1) begin errors++; $display("FAIL single_en got=%b exp=1", bus.mem_enable); end
        checks++; if (bus.mem_addr !== 32'h0000_0200 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL single_cmd got=%h/%b exp=00000200/0", bus.mem_addr, bus.mem_write); end
        wait_any_ack(who, cyc, d);
        checks++; if (who !== 0 || cyc !== 10) begin errors++; $display("FAIL single_ack who=%0d cyc=%0d exp=0/10", who, cyc); end
        checks++; if (d !== line_init(16)) begin errors++; $display("FAIL single_data got=%h exp=%h", d, line_init(16)); end
        @(posedge clk); #1 bus.req0_enable = 1'b0;
        @(negedge clk);
        checks++; if (bus.mem_enable !== 1'b0) begin errors++; $display("FAIL single_done got=%b exp=0", bus.mem_enable); end
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int who, cyc; logic [DW-1:0] d;
        int first;
        logic [DW-1:0] wb;
        first = FIXED;
        wb = {4{64'h1111_2222_3333_4444}};
        do_reset();
        @(posedge clk); #1;
        drive0(1'b1, 1'b0, 32'h0000_0000, '0);
        drive1(1'b1, 1'b1, 32'h0000_0400, wb);
        repeat (2) @(negedge clk);
        checks++; if (bus.mem_enable !== 1'b1 || bus.mem_addr !== (first == 1 ? 32'h400 : 32'h0) || bus.mem_write !== 1'(first)) begin
            errors++; $display("FAIL sim_first_cmd got=%b/%h/%b exp first=%0d", bus.mem_enable, bus.mem_addr, bus.mem_write, first); end
        wait_any_ack(who, cyc, d);
        checks++; if (who !== first || cyc !== 10) begin errors++; $display("FAIL sim_first_ack who=%0d cyc=%0d exp=%0d/10", who, cyc, first); end
        @(posedge clk); #1;
        if (first == 0) bus.req0_enable = 1'b0; else bus.req1_enable = 1'b0;
        @(negedge clk);
        checks++; if (bus.mem_enable !== 1'b0) begin errors++; $display("FAIL sim_gap1 got=%b exp=0", bus.mem_enable); end
        @(negedge clk);
        checks++; if (bus.mem_enable !== 1'b0) begin errors++; $display("FAIL sim_gap2 got=%b exp=0", bus.mem_enable); end
        @(negedge clk);
        checks++; if (bus.mem_enable !== 1'b1 || bus.mem_addr !== (first == 1 ? 32'h0 : 32'h400)) begin
            errors++; $display("FAIL sim_second_cmd got=%b/%h", bus.mem_enable, bus.mem_addr); end
        wait_any_ack(who, cyc, d);
        checks++; if (who !== 1 - first || cyc !== 10) begin errors++; $display("FAIL sim_second_ack who=%0d cyc=%0d exp=%0d/10", who, cyc, 1 - first); end
        @(posedge clk); #1;
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0);
        checks++; if (mem[32] !== wb) begin errors++; $display("FAIL sim_line32 got=%h exp=%h", mem[32], wb); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fairness();
        int who, cyc, exp_who; logic [DW-1:0] d;
        @(posedge clk); #1;
        drive0(1'b1, 1'b0, 32'h0000_0040, '0);
        drive1(1'b1, 1'b0, 32'h0000_0060, '0);
        for (int k = 0; k < 6; k++) begin
            exp_who = (FIXED == 1) ? 1 : (k % 2);
            wait_any_ack(who, cyc, d);
            checks++; if (who !== exp_who || d !== line_init(2 + exp_who)) begin
                errors++; $display("FAIL fair_grant%0d who=%0d exp=%0d data=%h", k, who, exp_who, d); end
        end
        @(posedge clk); #1;
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abandon();
        int who, cyc; logic [DW-1:0] d;
        int seen;
        @(posedge clk); #1 drive1(1'b1, 1'b0, 32'h0000_0600, '0);
        repeat (2) @(negedge clk);
        checks++; if (bus.mem_enable !== 1'b1 || bus.mem_addr !== 32'h600) begin errors++; $display("FAIL abn_issue got=%b/%h", bus.mem_enable, bus.mem_addr); end
        repeat (3) @(posedge clk);
        #1 bus.req1_enable = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_ack) begin
                seen = 1;
                checks++; if ({bus.req1_ack, bus.req0_ack} !== 2'b00) begin errors++; $display("FAIL abn_ack got=%b exp=00", {bus.req1_ack, bus.req0_ack}); end
                break;
            end
        end
        checks++; if (seen !== 1) begin errors++; $display("FAIL abn_memack got=timeout exp=ack"); end
        repeat (2) begin
            @(negedge clk);
            checks++; if (bus.mem_enable !== 1'b0) begin errors++; $display("FAIL abn_idle got=%b exp=0", bus.mem_enable); end
        end
        @(posedge clk); #1 drive0(1'b1, 1'b0, 32'h0000_0200, '0);
        repeat (2) @(negedge clk);
        wait_any_ack(who, cyc, d);
        checks++; if (who !== 0 || cyc !== 10 || d !== line_init(16)) begin
            errors++; $display("FAIL abn_next who=%0d cyc=%0d data=%h exp=0/10/%h", who, cyc, d, line_init(16)); end
        @(posedge clk); #1 bus.req0_enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stability();
        int bad, seen;
        logic [AW-1:0] bad_a;
        logic [DW-1:0] d1;
        d1 = {4{64'h5A5A_0F0F_C3C3_9696}};
        bad = 0; seen = 0; bad_a = '0;
        @(posedge clk); #1 drive0(1'b1, 1'b1, 32'h0000_0240, d1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        bus.req0_addr  = 32'h0000_0FE0;
        bus.req0_wdata = {8{32'h7777_7777}};
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_addr !== 32'h240 || bus.mem_wdata !== d1) begin bad++; bad_a = bus.mem_addr; end
            if (bus.req0_ack) begin seen = 1; break; end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stab_hold bad=%0d addr=%h exp=0/00000240", bad, bad_a); end
        checks++; if (seen !== 1) begin errors++; $display("FAIL stab_ack got=timeout exp=ack"); end
        @(posedge clk); #1 bus.req0_enable = 1'b0;
        @(negedge clk);
        checks++; if (bus.mem_addr !== 32'h240 || bus.mem_wdata !== d1) begin errors++; $display("FAIL stab_done addr=%h exp=00000240", bus.mem_addr); end
        checks++; if (mem[18] !== d1) begin errors++; $display("FAIL stab_line18 got=%h exp=%h", mem[18], d1); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int who, cyc, bad; logic [DW-1:0] d;
        bad = 0;
        @(posedge clk); #1 drive0(1'b1, 1'b0, 32'h0000_0020, '0);
        repeat (2) @(negedge clk);
        checks++; if (bus.mem_enable !== 1'b1 || bus.mem_addr !== 32'h20) begin errors++; $display("FAIL rmid_issue got=%b/%h", bus.mem_enable, bus.mem_addr); end
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({bus.mem_enable, bus.mem_write, bus.req0_ack, bus.req1_ack} !== 4'b0000 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
            errors++; $display("FAIL rmid_async en=%b wr=%b addr=%h acks=%b exp=all 0", bus.mem_enable, bus.mem_write, bus.mem_addr, {bus.req1_ack, bus.req0_ack}); end
        drive0(1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.mem_enable || bus.req0_ack || bus.req1_ack) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rmid_quiet bad=%0d exp=0", bad); end
        @(posedge clk); #1 drive0(1'b1, 1'b0, 32'h0000_0200, '0);
        repeat (2) @(negedge clk);
        wait_any_ack(who, cyc, d);
        checks++; if (who !== 0 || cyc !== 10 || d !== line_init(16)) begin
            errors++; $display("FAIL rmid_fresh who=%0d cyc=%0d data=%h exp=0/10/%h", who, cyc, d, line_init(16)); end
        @(posedge clk); #1 bus.req0_enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1;
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0);
        #1 rst_n = 1'b0;
        test_reset();
        test_single_fill();
        test_simultaneous();
        test_fairness();
        test_abandon();
        test_stability();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
